// File: rtl/hook_pkg.sv
// hook_pkg: shared types and constants for the cable launch controller.
//   cable_state_t  - grab-cycle FSM states (encoding is visible on the debug port)
//   obj_type_t     - object codes reported with a collision
//   *_DEF          - default frame budget and score values
//   return_divider - frame divider applied to the cable while it retracts
package hook_pkg;

  typedef enum logic [2:0] {
    ST_SWING   = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_EXTEND  = 3'd2,
    ST_RETRACT = 3'd3,
    ST_DELIVER = 3'd4
  } cable_state_t;

  typedef enum logic [1:0] {
    OBJ_NONE       = 2'd0,
    OBJ_SMALL_GOLD = 2'd1,
    OBJ_BIG_GOLD   = 2'd2,
    OBJ_ROCK       = 2'd3
  } obj_type_t;

  localparam int unsigned MAX_EXTEND_FRAMES_DEF = 90;
  localparam logic [7:0]  SMALL_GOLD_SCORE_DEF  = 8'd50;
  localparam logic [7:0]  BIG_GOLD_SCORE_DEF    = 8'd250;
  localparam logic [7:0]  ROCK_SCORE_DEF        = 8'd10;

  // Heavier loads come back slower: the cable only sees every Nth frame.
  function automatic logic [2:0] return_divider(input logic [1:0] obj);
    logic [2:0] n;
    case (obj_type_t'(obj))
      OBJ_SMALL_GOLD: n = 3'd2;
      OBJ_BIG_GOLD:   n = 3'd4;
      OBJ_ROCK:       n = 3'd3;
      default:        n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/frame_tick_divider.sv
// frame_tick_divider: passes one out of every N frame pulses.
//   clk, resetN   - clock, asynchronous active-low reset
//   startOfFrame  - one-cycle frame pulse
//   clear         - holds the divider count at zero
//   N             - divide ratio, 1..4
//   tick          - startOfFrame qualified by a zero count (combinational)
module frame_tick_divider
  import hook_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       clear,
  input  logic [2:0] N,
  output logic       tick
);

  logic [1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear) begin
      div_cnt_d = 2'd0;
    end else if (startOfFrame) begin
      if ({1'b0, div_cnt_q} == N - 3'd1) begin
        div_cnt_d = 2'd0;
      end else begin
        div_cnt_d = div_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_cnt_q <= 2'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // The first frame after the count is cleared always gets through.
  assign tick = startOfFrame & (div_cnt_q == 2'd0);

endmodule

// File: rtl/cable_launch_controller.sv
// cable_launch_controller: sequences one grab cycle of the swinging cable.
//   Inputs : clk, resetN (async, active low), startOfFrame (frame pulse),
//            launchKey (debounced level), roundActive, IsInCircular,
//            collision, objectType[1:0] (sampled with collision)
//   Outputs: launch_Cable, forceReturn, scoreValid (one-cycle pulses),
//            cableFrameTick (gated frame pulse for the cable motion module),
//            carrying, carriedType[1:0], scoreValue[7:0], state[2:0] (debug)
// All pulse outputs are single-cycle strobes with no backpressure: the
// consumer must act on them in the cycle they are high.
module cable_launch_controller
  import hook_pkg::*;
#(
  parameter int unsigned MAX_EXTEND_FRAMES = MAX_EXTEND_FRAMES_DEF,
  parameter logic [7:0]  SMALL_GOLD_SCORE  = SMALL_GOLD_SCORE_DEF,
  parameter logic [7:0]  BIG_GOLD_SCORE    = BIG_GOLD_SCORE_DEF,
  parameter logic [7:0]  ROCK_SCORE        = ROCK_SCORE_DEF
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       launchKey,
  input  logic       roundActive,
  input  logic       IsInCircular,
  input  logic       collision,
  input  logic [1:0] objectType,
  output logic       launch_Cable,
  output logic       forceReturn,
  output logic       cableFrameTick,
  output logic       carrying,
  output logic [1:0] carriedType,
  output logic       scoreValid,
  output logic [7:0] scoreValue,
  output logic [2:0] state
);

  localparam logic [7:0] LAST_FRAME = 8'(MAX_EXTEND_FRAMES - 1);

  cable_state_t state_q, state_d;
  logic [7:0]   frame_cnt_q, frame_cnt_d;
  logic         armed_q, armed_d;
  logic         carrying_q, carrying_d;
  logic [1:0]   carried_type_q, carried_type_d;
  logic         launch_key_q;
  logic         key_edge;
  logic         force_return;
  logic         div_tick;
  logic [2:0]   div_n;
  logic [7:0]   table_score;

  assign key_edge = launchKey & ~launch_key_q;

  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    armed_d        = armed_q;
    carrying_d     = carrying_q;
    carried_type_d = carried_type_q;
    force_return   = 1'b0;
    case (state_q)
      ST_SWING: begin
        // A key edge that does not qualify is simply lost.
        if (key_edge && IsInCircular && roundActive) begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d     = ST_EXTEND;
        frame_cnt_d = 8'd0;
        armed_d     = 1'b0;
      end
      ST_EXTEND: begin
        // The cable starts inside the pivot zone; it must leave it once
        // before a return to that zone can end the cycle.
        if (!IsInCircular) begin
          armed_d = 1'b1;
        end
        if (startOfFrame) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
        if (collision) begin
          carried_type_d = objectType;
          carrying_d     = (objectType != 2'd0);
          state_d        = ST_RETRACT;
        end else if (startOfFrame && frame_cnt_q == LAST_FRAME) begin
          force_return = 1'b1;
          carrying_d   = 1'b0;
          state_d      = ST_RETRACT;
        end
      end
      ST_RETRACT: begin
        // Keep arming here too, so a hit that lands before the cable
        // ever left the pivot zone cannot strand the cycle in RETRACT.
        if (!IsInCircular) begin
          armed_d = 1'b1;
        end
        if (armed_q && IsInCircular) begin
          state_d = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        state_d        = ST_SWING;
        carrying_d     = 1'b0;
        carried_type_d = 2'd0;
      end
      default: begin
        state_d = ST_SWING;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= ST_SWING;
      frame_cnt_q    <= 8'd0;
      armed_q        <= 1'b0;
      carrying_q     <= 1'b0;
      carried_type_q <= 2'd0;
      launch_key_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      armed_q        <= armed_d;
      carrying_q     <= carrying_d;
      carried_type_q <= carried_type_d;
      launch_key_q   <= launchKey;
    end
  end

  // An empty return (border hit or timeout) runs at full frame rate.
  assign div_n = carrying_q ? return_divider(carried_type_q) : 3'd1;

  frame_tick_divider u_divider (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .clear        (state_q != ST_RETRACT),
    .N            (div_n),
    .tick         (div_tick)
  );

  always_comb begin
    table_score = 8'd0;
    case (obj_type_t'(carried_type_q))
      OBJ_SMALL_GOLD: table_score = SMALL_GOLD_SCORE;
      OBJ_BIG_GOLD:   table_score = BIG_GOLD_SCORE;
      OBJ_ROCK:       table_score = ROCK_SCORE;
      default:        table_score = 8'd0;
    endcase
  end

  assign launch_Cable   = (state_q == ST_LAUNCH);
  assign forceReturn    = force_return;
  assign cableFrameTick = (state_q == ST_RETRACT) ? div_tick : startOfFrame;
  assign carrying       = carrying_q;
  assign carriedType    = carried_type_q;
  assign scoreValid     = (state_q == ST_DELIVER);
  assign scoreValue     = (state_q == ST_DELIVER && carrying_q) ? table_score : 8'd0;
  assign state          = state_q;

endmodule

// File: tb/tb_cable_launch_controller.sv
// Testbench for cable_launch_controller: directed grab scenarios with
// hand-computed expectations, then randomized traffic, all cross-checked
// every cycle against a behavioural model of the grab cycle.
module tb_cable_launch_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       launchKey = 1'b0;
  logic       roundActive = 1'b0;
  logic       IsInCircular = 1'b0;
  logic       collision = 1'b0;
  logic [1:0] objectType = 2'd0;
  logic       launch_Cable, forceReturn, cableFrameTick, carrying, scoreValid;
  logic [1:0] carriedType;
  logic [7:0] scoreValue;
  logic [2:0] state;

  cable_launch_controller dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .launchKey      (launchKey),
    .roundActive    (roundActive),
    .IsInCircular   (IsInCircular),
    .collision      (collision),
    .objectType     (objectType),
    .launch_Cable   (launch_Cable),
    .forceReturn    (forceReturn),
    .cableFrameTick (cableFrameTick),
    .carrying       (carrying),
    .carriedType    (carriedType),
    .scoreValid     (scoreValid),
    .scoreValue     (scoreValue),
    .state          (state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 swing, 1 launch, 2 extend, 3 retract, 4 deliver.
  int  m_st = 0;
  bit  m_kp = 0;
  bit  m_armed = 0;
  bit  m_carry = 0;
  int  m_ctype = 0;
  int  m_frames = 0;   // frames seen since the cable was fired
  int  m_rf = 0;       // frames seen since the return started
  logic [7:0] exp_q[$]; // scores the model has promised
  int  n_launch = 0;
  int  n_score = 0;

  function automatic int score_of(input int t);
    case (t)
      1: return 50;
      2: return 250;
      3: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic int div_of(input int t);
    case (t)
      1: return 2;
      2: return 4;
      3: return 3;
      default: return 1;
    endcase
  endfunction

  // Compare process: inputs are stable here, outputs are settled.
  always @(negedge clk) begin
    if (!resetN) begin
      m_st = 0; m_kp = 0; m_armed = 0; m_carry = 0; m_ctype = 0;
      m_frames = 0; m_rf = 0;
      exp_q.delete();
      chk("rst_state", state, 0);
      chk("rst_carrying", carrying, 0);
      chk("rst_carried_type", carriedType, 0);
      chk("rst_launch", launch_Cable, 0);
      chk("rst_force", forceReturn, 0);
      chk("rst_score_valid", scoreValid, 0);
      chk("rst_score_value", scoreValue, 0);
    end else begin
      bit e_force, e_tick, edge_seen;
      int n;
      n = m_carry ? div_of(m_ctype) : 1;
      e_force = (m_st == 2) && !collision && startOfFrame && (m_frames == 89);
      e_tick  = (m_st == 3) ? (startOfFrame && (m_rf % n) == 0) : startOfFrame;
      chk("state", state, m_st);
      chk("launch", launch_Cable, m_st == 1);
      chk("force_return", forceReturn, e_force);
      chk("frame_tick", cableFrameTick, e_tick);
      chk("carrying", carrying, m_carry);
      chk("carried_type", carriedType, m_ctype);
      chk("score_valid", scoreValid, m_st == 4);
      chk("score_value", scoreValue, (m_st == 4 && m_carry) ? score_of(m_ctype) : 0);
      if (launch_Cable) n_launch++;
      if (scoreValid) begin
        n_score++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL score_sb actual=%0d required=none t=%0t", scoreValue, $time);
        end else begin
          chk("score_sb", scoreValue, exp_q.pop_front());
        end
      end
      // advance the model to the next cycle
      edge_seen = launchKey && !m_kp;
      m_kp = launchKey;
      case (m_st)
        0: if (edge_seen && IsInCircular && roundActive) m_st = 1;
        1: begin m_st = 2; m_frames = 0; m_armed = 0; end
        2: begin
          if (!IsInCircular) m_armed = 1;
          if (collision) begin
            m_ctype = objectType; m_carry = (objectType != 0); m_st = 3; m_rf = 0;
          end else if (e_force) begin
            m_carry = 0; m_st = 3; m_rf = 0;
          end
          if (startOfFrame) m_frames++;
        end
        3: begin
          if (startOfFrame) m_rf++;
          if (m_armed && IsInCircular) begin
            m_st = 4;
            exp_q.push_back(8'(m_carry ? score_of(m_ctype) : 0));
          end
          if (!IsInCircular) m_armed = 1;
        end
        default: begin m_st = 0; m_carry = 0; m_ctype = 0; end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // One full grab. cf = frame number carrying the collision (0: none -> timeout).
  task automatic grab(input logic [1:0] t, input int cf, input int e_force,
                      input int e_ctype, input int e_carry, input int e_ticks,
                      input int e_score);
    int nforce, force_f, ticks;
    nforce = 0; force_f = 0; ticks = 0;
    launchKey = 0; IsInCircular = 1; roundActive = 1; collision = 0; startOfFrame = 0;
    next(); next();
    n_launch = 0;
    launchKey = 1;
    @(negedge clk) chk("pre_launch_state", state, 0);
    next();
    @(negedge clk) begin chk("launch_state", state, 1); chk("launch_pulse", launch_Cable, 1); end
    next();
    IsInCircular = 0;
    @(negedge clk) begin chk("extend_state", state, 2); chk("launch_once", launch_Cable, 0); end
    for (int f = 1; f <= 90; f++) begin
      next(); startOfFrame = 0; collision = 0;
      next(); startOfFrame = 1;
      if (f == cf) begin collision = 1; objectType = t; end
      @(negedge clk) if (forceReturn) begin nforce++; force_f = f; end
      if (f == cf) break;
    end
    next(); startOfFrame = 0; collision = 0; objectType = 0;
    @(negedge clk) begin
      chk("retract_state", state, 3);
      chk("grab_carrying", carrying, e_carry);
      chk("grab_carried_type", carriedType, e_ctype);
    end
    chk("force_count", nforce, e_force);
    if (e_force != 0) chk("force_frame", force_f, 90);
    for (int k = 0; k < 16; k++) begin
      next(); startOfFrame = 1;
      if (k == 5) launchKey = 0;
      if (k == 6) launchKey = 1;   // fresh key edge while retracting
      @(negedge clk) if (cableFrameTick) ticks++;
      next(); startOfFrame = 0;
    end
    chk("retract_ticks", ticks, e_ticks);
    next(); IsInCircular = 1;
    @(negedge clk) chk("still_retract", state, 3);
    next();
    @(negedge clk) begin
      chk("deliver_state", state, 4);
      chk("deliver_valid", scoreValid, 1);
      chk("deliver_value", scoreValue, e_score);
    end
    next();
    @(negedge clk) begin
      chk("back_to_swing", state, 0);
      chk("score_once", scoreValid, 0);
      chk("carry_cleared", carrying, 0);
    end
    repeat (60) next();   // key still held in a launchable position
    chk("single_launch", n_launch, 1);
    launchKey = 0;
    next();
  endtask

  task automatic reject(input logic ra, input logic ic);
    launchKey = 0; roundActive = ra; IsInCircular = ic; startOfFrame = 0; collision = 0;
    next();
    n_launch = 0;
    launchKey = 1;
    next(); next(); next();
    @(negedge clk) begin chk("reject_launch", n_launch, 0); chk("reject_state", state, 0); end
    launchKey = 0; roundActive = 1; IsInCircular = 1;
    next();
  endtask

  task automatic reset_in_retract();
    launchKey = 0; IsInCircular = 1; roundActive = 1; collision = 0; startOfFrame = 0;
    next();
    launchKey = 1;
    next(); next();
    IsInCircular = 0;
    next(); startOfFrame = 1; collision = 1; objectType = 2;
    next(); startOfFrame = 0; collision = 0; objectType = 0;
    next(); next();
    @(negedge clk) chk("pre_reset_retract", state, 3);
    IsInCircular = 1;   // would deliver at the next edge without the reset
    @(posedge clk);
    #3 resetN = 0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_carrying", carrying, 0);
    chk("async_rst_type", carriedType, 0);
    chk("async_rst_valid", scoreValid, 0);
    chk("async_rst_value", scoreValue, 0);
    n_score = 0;
    next(); next();
    resetN = 1; launchKey = 0;
    repeat (10) next();
    chk("no_score_after_reset", n_score, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    @(negedge clk) begin chk("reset_state_lit", state, 0); chk("reset_score_lit", scoreValue, 0); end
    next();
    resetN = 1;
    next();
    grab(2'd2, 5, 0, 2, 1, 4, 250);    // big gold, divider 4
    grab(2'd0, 0, 1, 0, 0, 16, 0);     // timeout, empty return
    grab(2'd3, 90, 0, 3, 1, 6, 10);    // rock hit on the timeout frame
    grab(2'd1, 3, 0, 1, 1, 8, 50);     // small gold, divider 2
    reject(1'b0, 1'b1);
    reject(1'b1, 1'b0);
    reset_in_retract();
    for (int i = 0; i < 3000; i++) begin
      next();
      startOfFrame = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) launchKey = ~launchKey;
      IsInCircular = ($urandom_range(0, 9) < 6);
      collision = ($urandom_range(0, 11) == 0);
      objectType = 2'($urandom_range(0, 3));
      roundActive = ($urandom_range(0, 9) != 0);
    end
    // drain whatever cycle is in flight back to SWING
    next(); launchKey = 0; startOfFrame = 0; collision = 1; IsInCircular = 0;
    next(); next(); collision = 0;
    next(); IsInCircular = 1;
    repeat (6) next();
    @(negedge clk) begin
      chk("drain_state", state, 0);
      chk("score_queue_empty", exp_q.size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cable_launch_controller.md
# cable_launch_controller

Sequences the swinging cable (hook) through one complete grab cycle: accepts the player's launch key, fires the cable, watches for an object hit or a timeout, and throttles the return speed by object weight. On return it delivers a score pulse. It sits between the keypad/game-timer logic and the cable motion module, and its frame-tick output replaces the raw `startOfFrame` feeding that module.

## Interface
- `MAX_EXTEND_FRAMES`, 90: frames allowed in EXTEND before a forced return (3 s at 30 Hz).
- `SMALL_GOLD_SCORE`, 50: score for object type 1.
- `BIG_GOLD_SCORE`, 250: score for object type 2.
- `ROCK_SCORE`, 10: score for object type 3.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `launchKey` in 1: debounced key level.
- `roundActive` in 1: game timer running.
- `IsInCircular` in 1: cable is at a swing/pivot position.
- `collision` in 1: cable tip touches an object or a border.
- `objectType` in 2: type of the touched item, sampled with `collision`; 0 = border/none, 1 = small gold, 2 = big gold, 3 = rock.
- `launch_Cable` out 1: one-cycle launch pulse to the cable.
- `forceReturn` out 1: one-cycle pulse, OR-ed into the cable's collision input.
- `cableFrameTick` out 1: gated frame pulse to the cable.
- `carrying` out 1: an object is attached.
- `carriedType` out 2: latched object type.
- `scoreValid` out 1: one-cycle score pulse.
- `scoreValue` out 8: score amount, valid with `scoreValid`.
- `state` out 3: current state, for debug.

## Operation
States are SWING=0, LAUNCH=1, EXTEND=2, RETRACT=3 and DELIVER=4.

Key edge detection:
- `keyEdge` = `launchKey` & ~`launchKey_d`, using a 1-cycle registered delay.
- Holding the key does not relaunch.

Transitions:
- **SWING → LAUNCH** when `keyEdge` & `IsInCircular` & `roundActive`. Otherwise the edge is dropped; there is no queueing.
- **LAUNCH → EXTEND** unconditionally. `launch_Cable` = 1 in LAUNCH only. On entry, `frameCnt` = 0 and `armed` = 0.
- **EXTEND**:
  - `armed` is set on the first cycle with `IsInCircular` = 0.
  - `frameCnt` increments on each `startOfFrame`.
  - If `collision`: latch `carriedType` = `objectType`, set `carrying` = (`objectType` != 0), go to RETRACT.
  - Else if `startOfFrame` and `frameCnt` == `MAX_EXTEND_FRAMES`-1: pulse `forceReturn`, `carrying` = 0, go to RETRACT.
  - If both happen in the same cycle, collision wins and `forceReturn` stays 0.
- **RETRACT → DELIVER** when `armed` & `IsInCircular`. `collision` is ignored in RETRACT.
- **DELIVER → SWING** after one cycle:
  - `scoreValid` = 1.
  - `scoreValue` = table[`carriedType`] if `carrying`, else 0.
  - `carrying` and `carriedType` clear on exit.
- `collision` and `launchKey` are ignored in SWING (collision only), LAUNCH, RETRACT and DELIVER.
- Deasserting `roundActive` mid-cycle does not abort; the cycle completes normally.

Return-speed divider N (used in RETRACT):
- Empty: N = 1.
- Small gold: N = 2.
- Rock: N = 3.
- Big gold: N = 4.

`cableFrameTick`:
- Equals `startOfFrame` in SWING, LAUNCH, EXTEND and DELIVER.
- In RETRACT, equals `startOfFrame` & (`divCnt` == 0). `divCnt` counts 0..N-1 on `startOfFrame` and is cleared on RETRACT entry.

Widths: `frameCnt` is 8 bits, `divCnt` is 2 bits, and score constants are 8-bit unsigned.

## Timing
- Reset (async, immediate) values:
  - State = SWING.
  - All pulse outputs = 0.
  - `carrying` = 0, `carriedType` = 0, `scoreValue` = 0.
  - `frameCnt` = 0, `divCnt` = 0, `armed` = 0, `launchKey_d` = 0.
- Launch latency: `launch_Cable` is high in the cycle after the key edge is sampled with the qualifying conditions.
- `forceReturn` and the RETRACT entry occur in the same cycle. `scoreValid` is high for exactly one cycle, one cycle after `IsInCircular` is seen in RETRACT.
- `cableFrameTick` is combinational from `startOfFrame` and registered state, so it adds zero latency.
- Reset mid-EXTEND or mid-RETRACT: return to SWING with no score pulse.

## Structure
- `hook_pkg` holds:
  - The state enum `cable_state_t`.
  - The object enum `obj_type_t`.
  - Score defaults.
  - The divider lookup function.
- Sub-module `frame_tick_divider` implements `divCnt`: inputs are `clk`, `resetN`, `startOfFrame`, `clear` and `N`; output is `tick`. The FSM stays in the top module.

## Test plan
- **Launch**: key edge with `IsInCircular` = 1 and `roundActive` = 1 → `launch_Cable` pulses for 1 cycle and `state` = 2. Key held for 100 cycles → no second launch.
- **Big-gold grab**: in EXTEND, `collision` with `objectType` = 2 → `carrying` = 1, `carriedType` = 2, and `cableFrameTick` fires on every 4th `startOfFrame`. `IsInCircular` → `scoreValid` with `scoreValue` = 250, then `state` = 0.
- **Timeout**: no collision for 90 frames → `forceReturn` pulses once at the 90th `startOfFrame`. The return gives divider 1 and `scoreValue` = 0.
- **Simultaneous events**: `collision` with `objectType` = 3 in the same cycle as the timeout frame → no `forceReturn`, `carriedType` = 3, return divider 3, and score 10 on delivery.
- **Rejection**: key edge with `roundActive` = 0, or with `IsInCircular` = 0, or while in RETRACT → no `launch_Cable`.
- **Reset**: `resetN` low mid-RETRACT → all outputs 0 and `state` = 0 immediately, with no `scoreValid` after release.
